// File: rtl/sram2rw_bm_ctrl.sv
// Two-port byte-masked SRAM controller: zero-fill sweep after reset, then two
// independent read/write ports with port-1 priority and write-first forwarding.
module sram2rw_bm_ctrl #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = WIDTH / 8
) (
  input  logic             CE,
  input  logic             RSTB,
  input  logic             CSB1,
  input  logic             WEB1,
  input  logic [NB-1:0]    BYTEMASK1,
  input  logic [AW-1:0]    A1,
  input  logic [WIDTH-1:0] I1,
  output logic [WIDTH-1:0] O1,
  output logic             VLD1,
  input  logic             CSB2,
  input  logic             WEB2,
  input  logic [NB-1:0]    BYTEMASK2,
  input  logic [AW-1:0]    A2,
  input  logic [WIDTH-1:0] I2,
  output logic [WIDTH-1:0] O2,
  output logic             VLD2,
  output logic             READY
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_reg;
  logic [AW-1:0]    cnt_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr1, rd1, wr2, rd2, same_addr;
  logic [WIDTH-1:0] rd_word1, rd_word2;

  // Gating on CSB first keeps X on an unselected port's other inputs from leaking.
  assign wr1       = (state_reg == RUN) && !CSB1 && !WEB1;
  assign rd1       = (state_reg == RUN) && !CSB1 &&  WEB1;
  assign wr2       = (state_reg == RUN) && !CSB2 && !WEB2;
  assign rd2       = (state_reg == RUN) && !CSB2 &&  WEB2;
  assign same_addr = (A1 == A2);

  // Each read sees the other port's same-cycle write lanes (write-first).
  for (genvar gi = 0; gi < NB; gi++) begin : g_fwd
    assign rd_word1[gi*8 +: 8] = (wr2 && same_addr && BYTEMASK2[gi]) ?
                                 I2[gi*8 +: 8] : mem[A1][gi*8 +: 8];
    assign rd_word2[gi*8 +: 8] = (wr1 && same_addr && BYTEMASK1[gi]) ?
                                 I1[gi*8 +: 8] : mem[A2][gi*8 +: 8];
  end

  // Storage has no reset; port 1 is written last so it wins shared lanes.
  always_ff @(posedge CE) begin
    if (RSTB && state_reg == INIT) begin
      mem[cnt_reg] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr2 && BYTEMASK2[b]) mem[A2][b*8 +: 8] <= I2[b*8 +: 8];
        if (wr1 && BYTEMASK1[b]) mem[A1][b*8 +: 8] <= I1[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
      READY     <= 1'b0;
      O1        <= '0;
      O2        <= '0;
      VLD1      <= 1'b0;
      VLD2      <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          cnt_reg <= cnt_reg + AW'(1);
          VLD1    <= 1'b0;
          VLD2    <= 1'b0;
          if (cnt_reg == AW'(DEPTH - 1)) begin
            state_reg <= RUN;
            READY     <= 1'b1;
          end
        end
        RUN: begin
          VLD1 <= rd1;
          VLD2 <= rd2;
          if (rd1) O1 <= rd_word1;
          if (rd2) O2 <= rd_word2;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram2rw_bm_ctrl.sv
// Randomised bench for sram2rw_bm_ctrl against a word-array reference model,
// plus directed byte-mask, collision, reset and wide-configuration scenarios.
module tb_sram2rw_bm_ctrl;

  logic        CE = 1'b0;
  logic        RSTB = 1'b0;
  logic        CSB1 = 1'b1, WEB1 = 1'b1, CSB2 = 1'b1, WEB2 = 1'b1;
  logic [3:0]  BYTEMASK1 = '0, BYTEMASK2 = '0;
  logic [5:0]  A1 = '0, A2 = '0;
  logic [31:0] I1 = '0, I2 = '0, O1, O2;
  logic        VLD1, VLD2, READY;

  logic        w_csb1 = 1'b1, w_web1 = 1'b1, w_csb2 = 1'b1, w_web2 = 1'b1;
  logic [7:0]  w_bm1 = '0, w_bm2 = '0;
  logic [3:0]  w_a1 = '0, w_a2 = '0;
  logic [63:0] w_i1 = '0, w_i2 = '0, w_o1, w_o2;
  logic        w_vld1, w_vld2, w_ready;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] model [64];
  logic [31:0] exp_o1 = '0, exp_o2 = '0;
  logic        exp_v1 = 1'b0, exp_v2 = 1'b0;
  bit          model_run = 1'b0;

  always #5 CE = ~CE;

  sram2rw_bm_ctrl #(.DEPTH(64), .WIDTH(32)) dut (
    .CE(CE), .RSTB(RSTB),
    .CSB1(CSB1), .WEB1(WEB1), .BYTEMASK1(BYTEMASK1), .A1(A1), .I1(I1), .O1(O1), .VLD1(VLD1),
    .CSB2(CSB2), .WEB2(WEB2), .BYTEMASK2(BYTEMASK2), .A2(A2), .I2(I2), .O2(O2), .VLD2(VLD2),
    .READY(READY)
  );

  sram2rw_bm_ctrl #(.DEPTH(16), .WIDTH(64)) dut_wide (
    .CE(CE), .RSTB(RSTB),
    .CSB1(w_csb1), .WEB1(w_web1), .BYTEMASK1(w_bm1), .A1(w_a1), .I1(w_i1), .O1(w_o1), .VLD1(w_vld1),
    .CSB2(w_csb2), .WEB2(w_web2), .BYTEMASK2(w_bm2), .A2(w_a2), .I2(w_i2), .O2(w_o2), .VLD2(w_vld2),
    .READY(w_ready)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] bits;
    for (int i = 0; i < 4; i++) bits[i*8 +: 8] = {8{m[i]}};
    return (old & ~bits) | (d & bits);
  endfunction

  // One clock of stimulus; the model then applies port 2, then port 1 (port 1 wins),
  // and any read returns the word as it stands after both writes.
  task automatic step(input logic c1, input logic w1, input logic [3:0] m1,
                      input logic [5:0] a1, input logic [31:0] d1,
                      input logic c2, input logic w2, input logic [3:0] m2,
                      input logic [5:0] a2, input logic [31:0] d2);
    CSB1 = c1; CSB2 = c2;
    if (c1) begin WEB1 = 'x; BYTEMASK1 = 'x; A1 = 'x; I1 = 'x; end
    else begin WEB1 = w1; BYTEMASK1 = m1; A1 = a1; I1 = d1; end
    if (c2) begin WEB2 = 'x; BYTEMASK2 = 'x; A2 = 'x; I2 = 'x; end
    else begin WEB2 = w2; BYTEMASK2 = m2; A2 = a2; I2 = d2; end
    @(posedge CE); #1;
    if (model_run) begin
      if (!c2 && !w2) model[a2] = merge(model[a2], d2, m2);
      if (!c1 && !w1) model[a1] = merge(model[a1], d1, m1);
      exp_v1 = !c1 && w1;
      exp_v2 = !c2 && w2;
      if (exp_v1) exp_o1 = model[a1];
      if (exp_v2) exp_o2 = model[a2];
    end else begin
      exp_v1 = 1'b0;
      exp_v2 = 1'b0;
    end
  endtask

  task automatic idle_step();
    step(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 1'b1, 4'h0, 6'd0, 32'h0);
  endtask

  task automatic rand_step();
    logic [5:0] a1, a2;
    a1 = 6'($urandom);
    a2 = ($urandom_range(0, 2) == 0) ? a1 : 6'($urandom);
    step($urandom_range(0, 3) == 0, 1'($urandom), 4'($urandom), a1, $urandom,
         $urandom_range(0, 3) == 0, 1'($urandom), 4'($urandom), a2, $urandom);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CE);
    #1;
    n_cmp++;
    if ({READY, VLD1, VLD2} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=000", {READY, VLD1, VLD2});
    end
    n_cmp++;
    if (O1 !== 32'h0 || O2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_data O1=%h O2=%h want=0", O1, O2);
    end
    $display("reset: held low, outputs %h %h ready=%b", O1, O2, READY);
  endtask

  // Called right after RSTB is released (1 time unit after an edge).
  task automatic test_init_sweep(input string tag);
    model_run = 1'b0;
    exp_o1 = '0; exp_o2 = '0;
    for (int k = 1; k <= 64; k++) begin
      rand_step();
      n_cmp++;
      if (READY !== (k == 64)) begin
        n_fail++; $display("FAIL %s_ready edge=%0d got=%b want=%b", tag, k, READY, k == 64);
      end
      n_cmp++;
      if ({VLD1, VLD2} !== 2'b00 || O1 !== 32'h0 || O2 !== 32'h0) begin
        n_fail++; $display("FAIL %s_ignore edge=%0d vld=%b%b O1=%h O2=%h want zero",
                           tag, k, VLD1, VLD2, O1, O2);
      end
    end
    for (int i = 0; i < 64; i++) model[i] = '0;
    model_run = 1'b1;
    $display("%s: READY after 64 edges = %b", tag, READY);
  endtask

  task automatic test_clear_read(input string tag);
    for (int a = 0; a < 64; a++) begin
      step(1'b0, 1'b1, 4'h0, 6'(a), 32'h0, 1'b0, 1'b1, 4'h0, 6'(a), 32'h0);
      n_cmp++;
      if (VLD1 !== 1'b1 || VLD2 !== 1'b1 || O1 !== 32'h0 || O2 !== 32'h0) begin
        n_fail++; $display("FAIL %s addr=%0d got vld=%b%b O1=%h O2=%h want vld=11 data=0",
                           tag, a, VLD1, VLD2, O1, O2);
      end
    end
    $display("%s: read all 64 addresses on both ports", tag);
  endtask

  task automatic test_byte_mask();
    step(1'b0, 1'b0, 4'hF, 6'd5, 32'hAABBCCDD, 1'b1, 1'b1, 4'h0, 6'd0, 32'h0);
    step(1'b0, 1'b0, 4'h5, 6'd5, 32'h11223344, 1'b1, 1'b1, 4'h0, 6'd0, 32'h0);
    step(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 1'b1, 4'h0, 6'd5, 32'h0);
    n_cmp++;
    if (O2 !== 32'hAA22CC44 || VLD2 !== 1'b1) begin
      n_fail++; $display("FAIL byte_mask O2=%h vld=%b want AA22CC44 vld=1", O2, VLD2);
    end
    step(1'b0, 1'b0, 4'h0, 6'd5, 32'h0, 1'b1, 1'b1, 4'h0, 6'd0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 6'd5, 32'h0, 1'b0, 1'b1, 4'h0, 6'd5, 32'h0);
    n_cmp++;
    if (O1 !== 32'hAA22CC44 || O2 !== 32'hAA22CC44 || VLD1 !== 1'b1 || VLD2 !== 1'b1) begin
      n_fail++; $display("FAIL dual_read O1=%h O2=%h want AA22CC44 on both", O1, O2);
    end
    $display("byte_mask: O1=%h O2=%h", O1, O2);
  endtask

  task automatic test_dual_write();
    step(1'b0, 1'b0, 4'h3, 6'd9, 32'h000000FF, 1'b0, 1'b0, 4'hE, 6'd9, 32'hFFFFFF00);
    n_cmp++;
    if (VLD1 !== 1'b0 || VLD2 !== 1'b0) begin
      n_fail++; $display("FAIL write_no_vld vld=%b%b want 00", VLD1, VLD2);
    end
    step(1'b0, 1'b1, 4'h0, 6'd9, 32'h0, 1'b1, 1'b1, 4'h0, 6'd0, 32'h0);
    n_cmp++;
    if (O1 !== 32'hFFFF00FF || VLD1 !== 1'b1) begin
      n_fail++; $display("FAIL dual_write O1=%h want FFFF00FF", O1);
    end
    $display("dual_write: O1=%h", O1);
  endtask

  task automatic test_forward();
    step(1'b0, 1'b0, 4'hF, 6'd3, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h0, 6'd0, 32'h0);
    step(1'b0, 1'b0, 4'h8, 6'd3, 32'h12345678, 1'b0, 1'b1, 4'h0, 6'd3, 32'h0);
    n_cmp++;
    if (O2 !== 32'h12FFFFFF || VLD2 !== 1'b1) begin
      n_fail++; $display("FAIL forward O2=%h vld=%b want 12FFFFFF vld=1", O2, VLD2);
    end
    $display("forward: O2=%h", O2);
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      rand_step();
      n_cmp++;
      if (VLD1 !== exp_v1 || O1 !== exp_o1) begin
        n_fail++; $display("FAIL rand_p1 t=%0d got vld=%b O1=%h want vld=%b O1=%h",
                           t, VLD1, O1, exp_v1, exp_o1);
      end
      n_cmp++;
      if (VLD2 !== exp_v2 || O2 !== exp_o2) begin
        n_fail++; $display("FAIL rand_p2 t=%0d got vld=%b O2=%h want vld=%b O2=%h",
                           t, VLD2, O2, exp_v2, exp_o2);
      end
    end
    $display("random: %0d cycles, last O1=%h O2=%h", n, O1, O2);
  endtask

  task automatic test_reset_mid_run();
    step(1'b0, 1'b0, 4'hF, 6'd7, 32'hDEADBEEF, 1'b1, 1'b1, 4'h0, 6'd0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 6'd7, 32'h0, 1'b0, 1'b1, 4'h0, 6'd7, 32'h0);
    #2 RSTB = 1'b0;
    #1;
    n_cmp++;
    if (O1 !== 32'h0 || O2 !== 32'h0 || {READY, VLD1, VLD2} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset_run O1=%h O2=%h flags=%b want all zero",
                         O1, O2, {READY, VLD1, VLD2});
    end
    idle_step();
    RSTB = 1'b1;
    model_run = 1'b0;
    // Let INIT run 30 cycles, then pulse reset for one cycle.
    for (int k = 0; k < 30; k++) rand_step();
    RSTB = 1'b0;
    #1;
    n_cmp++;
    if (O1 !== 32'h0 || O2 !== 32'h0 || {READY, VLD1, VLD2} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset_init O1=%h O2=%h flags=%b want all zero",
                         O1, O2, {READY, VLD1, VLD2});
    end
    idle_step();
    RSTB = 1'b1;
    $display("reset_mid: pulses applied in RUN and at INIT cycle 30");
  endtask

  task automatic test_wide();
    n_cmp++;
    if (w_ready !== 1'b1) begin
      n_fail++; $display("FAIL wide_ready got=%b want=1", w_ready);
    end
    w_csb1 = 1'b0; w_web1 = 1'b0; w_bm1 = 8'h80; w_a1 = 4'd15; w_i1 = '1;
    @(posedge CE); #1;
    w_web1 = 1'b1;
    w_csb2 = 1'b0; w_web2 = 1'b1; w_a2 = 4'd15;
    @(posedge CE); #1;
    w_csb1 = 1'b1; w_csb2 = 1'b1;
    n_cmp++;
    if (w_o1 !== 64'hFF00000000000000 || w_vld1 !== 1'b1) begin
      n_fail++; $display("FAIL wide_p1 O1=%h vld=%b want FF00000000000000", w_o1, w_vld1);
    end
    n_cmp++;
    if (w_o2 !== 64'hFF00000000000000 || w_vld2 !== 1'b1) begin
      n_fail++; $display("FAIL wide_p2 O2=%h vld=%b want FF00000000000000", w_o2, w_vld2);
    end
    $display("wide: O1=%h O2=%h", w_o1, w_o2);
  endtask

  initial begin
    test_reset();
    @(posedge CE); #1;
    RSTB = 1'b1;
    test_init_sweep("init");
    test_clear_read("clear_read");
    test_byte_mask();
    test_dual_write();
    test_forward();
    test_random(400);
    test_reset_mid_run();
    test_init_sweep("reinit");
    test_clear_read("reinit_read");
    test_random(200);
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram2rw_bm_ctrl.md
SRAM2RW_BM_CTRL -- requirements
Module: sram2rw_bm_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of words; power of two, 16..1024.
REQ-002 SHALL have parameter WIDTH, default 32, word width in bits; multiple of 8, 8..128.
REQ-003 SHALL have derived localparams AW = clog2(DEPTH) and NB = WIDTH/8 (byte lanes).
REQ-004 SHALL have port CE, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port RSTB, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port CSB1, input, 1 bit: port-1 select, active-low.
REQ-007 SHALL have port WEB1, input, 1 bit: port-1 write enable, active-low; high means read.
REQ-008 SHALL have port BYTEMASK1, input, NB bits: port-1 byte-lane write enables, active-high.
REQ-009 SHALL have port A1, input, AW bits: port-1 address.
REQ-010 SHALL have port I1, input, WIDTH bits: port-1 write data.
REQ-011 SHALL have port O1, output, WIDTH bits: port-1 registered read data.
REQ-012 SHALL have port VLD1, output, 1 bit: O1 holds data from a read issued the previous cycle.
REQ-013 SHALL have ports CSB2, WEB2, BYTEMASK2, A2, I2, O2 and VLD2, identical to port 1.
REQ-014 SHALL have port READY, output, 1 bit: initialisation done, accesses accepted.

Function
REQ-015 Storage SHALL be a behavioural array of DEPTH x WIDTH bits, written and read only on the rising edge of CE.
REQ-016 The FSM SHALL have two states, INIT and RUN; INIT is entered on reset.
REQ-017 In INIT, an AW-bit counter SHALL write all-zero words to addresses 0..DEPTH-1, one per cycle, in ascending order.
REQ-018 INIT SHALL move to RUN on the edge that writes address DEPTH-1; READY SHALL rise on that edge, exactly DEPTH cycles after reset deassertion.
REQ-019 In INIT, port requests SHALL be ignored: no writes, VLDx held 0, Ox held 0.
REQ-020 In RUN, an access on port x SHALL be accepted on an edge where CSBx=0.
REQ-021 An accepted write SHALL update only the byte lanes whose BYTEMASKx bit is 1; a write with mask 0 changes nothing.
REQ-022 An accepted read (WEBx=1) SHALL load Ox and set VLDx=1 on the same edge, giving 1-cycle latency.
REQ-023 On an edge with no accepted read on port x, VLDx SHALL be 0 and Ox SHALL hold its previous value.
REQ-024 When both ports write the same address in the same cycle, each byte lane SHALL take port-1 data if BYTEMASK1 is set, else port-2 data if BYTEMASK2 is set, else keep the old value.
REQ-025 When one port reads an address the other port writes in the same cycle, the read SHALL return the merged post-write word (write-first forwarding, per byte lane).
REQ-026 When both ports read the same address, both SHALL return identical data.
REQ-027 Addresses SHALL be used modulo DEPTH; there is no out-of-range error.
REQ-028 X on inputs of an unselected port (CSBx=1) SHALL NOT affect array contents or outputs.

Reset
REQ-029 RSTB low SHALL asynchronously force O1=O2=0, VLD1=VLD2=0, READY=0, FSM=INIT and the init counter to 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL abort any in-flight access; after release, the full DEPTH-cycle clear SHALL rerun.
REQ-031 Array contents SHALL NOT be cleared by reset itself, only by the INIT sweep.

Verification
REQ-032 Reset release with DEPTH=64, then read every address on both ports -> READY rises exactly 64 cycles after release; all reads return 0 with VLD=1 one cycle after issue.
REQ-033 Port 1 writes 0xAABBCCDD to addr 5 with mask 4'b1111, then writes 0x11223344 to addr 5 with mask 4'b0101; port 2 reads addr 5 -> O2=0xAA22CC44, VLD2=1.
REQ-034 Same cycle: port 1 writes 0x000000FF to addr 9 with mask 4'b0011, port 2 writes 0xFFFFFF00 to addr 9 with mask 4'b1110; then read addr 9 -> 0xFFFF00FF.
REQ-035 Same cycle: port 1 writes 0x12345678 to addr 3 with mask 4'b1000; old word 0xFFFFFFFF; port 2 reads addr 3 -> O2=0x12FFFFFF.
REQ-036 RSTB pulsed low for 1 cycle at cycle 30 of INIT -> outputs zero immediately; READY rises 64 cycles after release.
REQ-037 WIDTH=64 and DEPTH=16: mask 8'h80 write of all-ones to addr 15, then read -> 0xFF00000000000000.
